plot_arbiter: RTL and testbench

Shares the single VGA framebuffer write port (`x`, `y`, `color`, `plot`) among three pixel sources: the game processor, the obstacle/trail renderer, and a built-in full-screen clear sweeper. It sits between the processor/renderer and the VGA adapter. It replaces the direct wiring of processor plot outputs to the adapter, and guarantees at most one pixel write per clock. Handshakes are registered req/gnt. The clear sweep has absolute priority, and the two external requesters are served round-robin.

---
 rtl/plot_pkg.sv | 36 +++
 rtl/clear_sweeper.sv | 51 +++++
 rtl/plot_arbiter.sv | 151 +++++++++++++++
 tb/tb_plot_arbiter.sv | 359 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/plot_pkg.sv
// Shared constants and types for the framebuffer write-port arbiter.
// Screen geometry, pixel field widths, colour names and FSM/requester encodings.
package plot_pkg;

    localparam int X_MAX = 160;
    localparam int Y_MAX = 120;
    localparam int X_W   = 8;
    localparam int Y_W   = 7;
    localparam int C_W   = 3;

    localparam logic [C_W-1:0] BLACK   = 3'b000;
    localparam logic [C_W-1:0] BLUE    = 3'b001;
    localparam logic [C_W-1:0] GREEN   = 3'b010;
    localparam logic [C_W-1:0] CYAN    = 3'b011;
    localparam logic [C_W-1:0] RED     = 3'b100;
    localparam logic [C_W-1:0] MAGENTA = 3'b101;
    localparam logic [C_W-1:0] YELLOW  = 3'b110;
    localparam logic [C_W-1:0] WHITE   = 3'b111;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } plot_state_t;

    typedef enum logic {
        REQ_PROC = 1'b0,
        REQ_OBS  = 1'b1
    } req_id_t;

    // True when (x, y) lies inside an x_max by y_max screen.
    function automatic logic on_screen(input logic [X_W-1:0] x, input logic [Y_W-1:0] y,
                                       input int x_max, input int y_max);
        return (int'(x) < x_max) && (int'(y) < y_max);
    endfunction

endpackage

// File: rtl/clear_sweeper.sv
// Row-major x/y counter for the full-screen clear. next_x/next_y is the pixel
// to be issued at the coming edge; done marks the last pixel being on display.
module clear_sweeper
    import plot_pkg::*;
#(
    parameter int X_MAX = plot_pkg::X_MAX,
    parameter int Y_MAX = plot_pkg::Y_MAX
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    input  logic           step,
    output logic [X_W-1:0] next_x,
    output logic [Y_W-1:0] next_y,
    output logic           done
);

    localparam logic [X_W-1:0] X_LAST = X_W'(X_MAX - 1);
    localparam logic [Y_W-1:0] Y_LAST = Y_W'(Y_MAX - 1);

    logic [X_W-1:0] x;
    logic [Y_W-1:0] y;

    // A start always restarts from the origin, whatever the counters held.
    always_comb begin
        next_x = '0;
        next_y = '0;
        if (!start) begin
            if (x == X_LAST) begin
                next_x = '0;
                next_y = y + 1'b1;
            end else begin
                next_x = x + 1'b1;
                next_y = y;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            x <= '0;
            y <= '0;
        end else if (start || step) begin
            x <= next_x;
            y <= next_y;
        end
    end

    assign done = (x == X_LAST) && (y == Y_LAST);

endmodule

// File: rtl/plot_arbiter.sv
// Arbitrates the single VGA framebuffer write port between the clear sweep
// (absolute priority) and two round-robin pixel requesters.
module plot_arbiter
    import plot_pkg::*;
#(
    parameter int             X_MAX       = plot_pkg::X_MAX,
    parameter int             Y_MAX       = plot_pkg::Y_MAX,
    parameter logic [C_W-1:0] CLEAR_COLOR = BLACK
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           clear_req,
    output logic           clear_busy,
    input  logic           p_req,
    input  logic [X_W-1:0] p_x,
    input  logic [Y_W-1:0] p_y,
    input  logic [C_W-1:0] p_color,
    output logic           p_gnt,
    input  logic           o_req,
    input  logic [X_W-1:0] o_x,
    input  logic [Y_W-1:0] o_y,
    input  logic [C_W-1:0] o_color,
    output logic           o_gnt,
    output logic [X_W-1:0] vga_x,
    output logic [Y_W-1:0] vga_y,
    output logic [C_W-1:0] vga_color,
    output logic           vga_plot,
    output logic           oob,
    output plot_state_t    dbg_state
);

    // Handshake: a requester raises req with its pixel stable and holds both
    // until it sees its one-cycle gnt; gnt is registered, so a req still high
    // while its gnt is high is not eligible again (no double grant).

    plot_state_t    state, state_next;
    req_id_t        last_win;
    logic           sweep_start, sweep_step, sweep_done, arb_en;
    logic [X_W-1:0] sweep_x;
    logic [Y_W-1:0] sweep_y;
    logic           p_elig, o_elig, win_p, win_o, win_on;
    logic [X_W-1:0] win_x;
    logic [Y_W-1:0] win_y;
    logic [C_W-1:0] win_color;

    clear_sweeper #(
        .X_MAX(X_MAX),
        .Y_MAX(Y_MAX)
    ) u_sweeper (
        .clk   (clk),
        .reset (reset),
        .start (sweep_start),
        .step  (sweep_step),
        .next_x(sweep_x),
        .next_y(sweep_y),
        .done  (sweep_done)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    // The edge that retires the last sweep pixel also arbitrates, so a
    // pending request is granted in the cycle clear_busy falls.
    always_comb begin
        state_next  = state;
        sweep_start = 1'b0;
        sweep_step  = 1'b0;
        arb_en      = 1'b0;
        case (state)
            IDLE: begin
                if (clear_req) begin
                    state_next  = CLEAR;
                    sweep_start = 1'b1;
                end else begin
                    arb_en = 1'b1;
                end
            end
            CLEAR: begin
                if (sweep_done) begin
                    state_next = IDLE;
                    arb_en     = 1'b1;
                end else begin
                    sweep_step = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        p_elig = p_req && !p_gnt;
        o_elig = o_req && !o_gnt;
        win_p  = 1'b0;
        win_o  = 1'b0;
        if (arb_en) begin
            if (p_elig && o_elig) begin
                if (last_win == REQ_PROC) win_o = 1'b1;
                else                      win_p = 1'b1;
            end else if (p_elig) begin
                win_p = 1'b1;
            end else if (o_elig) begin
                win_o = 1'b1;
            end
        end
        win_x     = win_p ? p_x     : o_x;
        win_y     = win_p ? p_y     : o_y;
        win_color = win_p ? p_color : o_color;
        win_on    = on_screen(win_x, win_y, X_MAX, Y_MAX);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            p_gnt     <= 1'b0;
            o_gnt     <= 1'b0;
            vga_x     <= '0;
            vga_y     <= '0;
            vga_color <= '0;
            vga_plot  <= 1'b0;
            oob       <= 1'b0;
            last_win  <= REQ_OBS;
        end else begin
            p_gnt    <= win_p;
            o_gnt    <= win_o;
            vga_plot <= 1'b0;
            oob      <= 1'b0;
            if (sweep_start || sweep_step) begin
                vga_x     <= sweep_x;
                vga_y     <= sweep_y;
                vga_color <= CLEAR_COLOR;
                vga_plot  <= 1'b1;
            end else if (win_p || win_o) begin
                last_win <= win_p ? REQ_PROC : REQ_OBS;
                // Off-screen pixels complete the handshake but never reach the adapter.
                if (win_on) begin
                    vga_x     <= win_x;
                    vga_y     <= win_y;
                    vga_color <= win_color;
                    vga_plot  <= 1'b1;
                end else begin
                    oob <= 1'b1;
                end
            end
        end
    end

    assign clear_busy = (state == CLEAR);
    assign dbg_state  = state;

endmodule

// File: tb/tb_plot_arbiter.sv
// Self-checking bench for plot_arbiter: directed scenarios plus a randomized
// two-requester run checked against a transaction-level reference model.
module tb_plot_arbiter;
    import plot_pkg::*;

    logic        clk;
    logic        reset;
    logic        clear_req;
    logic        clear_busy;
    logic        p_req;
    logic [7:0]  p_x;
    logic [6:0]  p_y;
    logic [2:0]  p_color;
    logic        p_gnt;
    logic        o_req;
    logic [7:0]  o_x;
    logic [6:0]  o_y;
    logic [2:0]  o_color;
    logic        o_gnt;
    logic [7:0]  vga_x;
    logic [6:0]  vga_y;
    logic [2:0]  vga_color;
    logic        vga_plot;
    logic        oob;
    plot_state_t dbg_state;

    int checks = 0;
    int errors = 0;

    plot_arbiter dut (
        .clk       (clk),
        .reset     (reset),
        .clear_req (clear_req),
        .clear_busy(clear_busy),
        .p_req     (p_req),
        .p_x       (p_x),
        .p_y       (p_y),
        .p_color   (p_color),
        .p_gnt     (p_gnt),
        .o_req     (o_req),
        .o_x       (o_x),
        .o_y       (o_y),
        .o_color   (o_color),
        .o_gnt     (o_gnt),
        .vga_x     (vga_x),
        .vga_y     (vga_y),
        .vga_color (vga_color),
        .vga_plot  (vga_plot),
        .oob       (oob),
        .dbg_state (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL timeout simulation did not finish within 1000000 time units");
        $fatal(1, "timeout");
    end

    // Leaves the bench 1 time unit after a rising edge with the DUT idle.
    task automatic reset_dut();
        clear_req = 1'b0;
        p_req     = 1'b0;
        o_req     = 1'b0;
        reset     = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        clear_req = 1'b0; p_req = 1'b0; o_req = 1'b0;
        p_x = '0; p_y = '0; p_color = '0;
        o_x = '0; o_y = '0; o_color = '0;
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({p_gnt, o_gnt} !== 2'b00) begin
            errors++; $display("FAIL reset_gnt got %b expected 00", {p_gnt, o_gnt});
        end
        checks++;
        if ({vga_plot, oob, clear_busy} !== 3'b000) begin
            errors++; $display("FAIL reset_flags got %b expected 000", {vga_plot, oob, clear_busy});
        end
        checks++;
        if ({vga_x, vga_y, vga_color} !== 18'd0) begin
            errors++; $display("FAIL reset_pixel got %0d,%0d,%0d expected 0,0,0", vga_x, vga_y, vga_color);
        end
        checks++;
        if (dbg_state !== IDLE) begin
            errors++; $display("FAIL reset_state got %0d expected %0d", dbg_state, IDLE);
        end
    endtask

    task automatic test_single();
        reset_dut();
        p_req = 1'b1; p_x = 8'd10; p_y = 7'd20; p_color = 3'b100;
        @(posedge clk); #1;
        checks++;
        if ({p_gnt, o_gnt, vga_plot, oob} !== 4'b1010) begin
            errors++; $display("FAIL single_grant got gnt_p/gnt_o/plot/oob=%b expected 1010", {p_gnt, o_gnt, vga_plot, oob});
        end
        checks++;
        if ({vga_x, vga_y, vga_color} !== {8'd10, 7'd20, 3'd4}) begin
            errors++; $display("FAIL single_pixel got %0d,%0d,%0d expected 10,20,4", vga_x, vga_y, vga_color);
        end
        @(posedge clk); #1;
        checks++;
        if ({p_gnt, vga_plot} !== 2'b00) begin
            errors++; $display("FAIL single_no_regrant got gnt/plot=%b expected 00", {p_gnt, vga_plot});
        end
        checks++;
        if (vga_x !== 8'd10) begin
            errors++; $display("FAIL single_hold_x got %0d expected 10", vga_x);
        end
        p_req = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        logic exp_p;
        reset_dut();
        p_req = 1'b1; p_x = 8'd1; p_y = 7'd2; p_color = 3'd1;
        o_req = 1'b1; o_x = 8'd3; o_y = 7'd4; o_color = 3'd6;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            exp_p = (i % 2 == 0);
            checks++;
            if ({p_gnt, o_gnt, vga_plot} !== {exp_p, !exp_p, 1'b1}) begin
                errors++; $display("FAIL b2b_grant cycle %0d got p/o/plot=%b expected %b", i, {p_gnt, o_gnt, vga_plot}, {exp_p, !exp_p, 1'b1});
            end
            checks++;
            if (vga_x !== (exp_p ? 8'd1 : 8'd3)) begin
                errors++; $display("FAIL b2b_pixel cycle %0d got x=%0d expected %0d", i, vga_x, exp_p ? 1 : 3);
            end
        end
        p_req = 1'b0; o_req = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_clear();
        logic [7:0] ex;
        logic [6:0] ey;
        int bad;
        int first_bad;
        reset_dut();
        ex = '0; ey = '0; bad = 0; first_bad = -1;
        clear_req = 1'b1;
        @(posedge clk); #1;
        clear_req = 1'b0;
        for (int c = 0; c < 19200; c++) begin
            if (!(clear_busy === 1'b1 && vga_plot === 1'b1 && vga_x === ex && vga_y === ey &&
                  vga_color === 3'd0 && p_gnt === 1'b0 && o_gnt === 1'b0 && oob === 1'b0)) begin
                if (bad == 0) first_bad = c;
                bad++;
            end
            if (c == 100) begin
                o_req = 1'b1; o_x = 8'd5; o_y = 7'd6; o_color = 3'd2;
            end
            clear_req = (c == 5000);
            if (ex == 8'd159) begin
                ex = '0; ey = ey + 7'd1;
            end else begin
                ex = ex + 8'd1;
            end
            @(posedge clk); #1;
        end
        clear_req = 1'b0;
        checks++;
        if (bad !== 0) begin
            errors++; $display("FAIL sweep_sequence got %0d bad cycles (first at %0d) expected 0", bad, first_bad);
        end
        checks++;
        if ({clear_busy, o_gnt, vga_plot} !== 3'b011) begin
            errors++; $display("FAIL sweep_end_grant got busy/o_gnt/plot=%b expected 011", {clear_busy, o_gnt, vga_plot});
        end
        checks++;
        if ({vga_x, vga_y, vga_color} !== {8'd5, 7'd6, 3'd2}) begin
            errors++; $display("FAIL sweep_end_pixel got %0d,%0d,%0d expected 5,6,2", vga_x, vga_y, vga_color);
        end
        o_req = 1'b0;
        @(posedge clk); #1;
        checks++;
        if ({clear_busy, o_gnt, vga_plot} !== 3'b000) begin
            errors++; $display("FAIL sweep_no_restart got busy/o_gnt/plot=%b expected 000", {clear_busy, o_gnt, vga_plot});
        end
    endtask

    task automatic test_oob();
        reset_dut();
        p_req = 1'b1; p_x = 8'd200; p_y = 7'd5; p_color = 3'd7;
        @(posedge clk); #1;
        checks++;
        if ({p_gnt, oob, vga_plot} !== 3'b110) begin
            errors++; $display("FAIL oob_x got gnt/oob/plot=%b expected 110", {p_gnt, oob, vga_plot});
        end
        p_req = 1'b0;
        @(posedge clk); #1;
        checks++;
        if ({p_gnt, oob} !== 2'b00) begin
            errors++; $display("FAIL oob_pulse got gnt/oob=%b expected 00", {p_gnt, oob});
        end
        p_req = 1'b1; p_x = 8'd159; p_y = 7'd119; p_color = 3'd5;
        @(posedge clk); #1;
        checks++;
        if ({p_gnt, oob, vga_plot} !== 3'b101) begin
            errors++; $display("FAIL edge_pixel_flags got gnt/oob/plot=%b expected 101", {p_gnt, oob, vga_plot});
        end
        checks++;
        if ({vga_x, vga_y, vga_color} !== {8'd159, 7'd119, 3'd5}) begin
            errors++; $display("FAIL edge_pixel got %0d,%0d,%0d expected 159,119,5", vga_x, vga_y, vga_color);
        end
        p_req = 1'b0;
        o_req = 1'b1; o_x = 8'd10; o_y = 7'd120; o_color = 3'd3;
        @(posedge clk); #1;
        checks++;
        if ({o_gnt, oob, vga_plot} !== 3'b110) begin
            errors++; $display("FAIL oob_y got gnt/oob/plot=%b expected 110", {o_gnt, oob, vga_plot});
        end
        o_req = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_collision_and_reset_mid_sweep();
        reset_dut();
        clear_req = 1'b1;
        p_req = 1'b1; p_x = 8'd7; p_y = 7'd8; p_color = 3'd1;
        @(posedge clk); #1;
        clear_req = 1'b0;
        checks++;
        if ({p_gnt, clear_busy, vga_plot} !== 3'b011) begin
            errors++; $display("FAIL collision got gnt/busy/plot=%b expected 011", {p_gnt, clear_busy, vga_plot});
        end
        checks++;
        if ({vga_x, vga_y} !== 15'd0) begin
            errors++; $display("FAIL collision_first_pixel got %0d,%0d expected 0,0", vga_x, vga_y);
        end
        repeat (30 * 160 + 50) @(posedge clk);
        #1;
        checks++;
        if ({vga_x, vga_y, p_gnt} !== {8'd50, 7'd30, 1'b0}) begin
            errors++; $display("FAIL mid_sweep_pos got %0d,%0d gnt=%b expected 50,30 gnt=0", vga_x, vga_y, p_gnt);
        end
        #2 reset = 1'b0;
        #1;
        checks++;
        if ({clear_busy, vga_plot, p_gnt, o_gnt, oob} !== 5'd0) begin
            errors++; $display("FAIL async_reset_flags got %b expected 00000", {clear_busy, vga_plot, p_gnt, o_gnt, oob});
        end
        checks++;
        if ({vga_x, vga_y, vga_color} !== 18'd0) begin
            errors++; $display("FAIL async_reset_pixel got %0d,%0d,%0d expected 0,0,0", vga_x, vga_y, vga_color);
        end
        p_req = 1'b0;
        @(posedge clk);
        #1 reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({clear_busy, vga_plot, dbg_state} !== {1'b0, 1'b0, IDLE}) begin
            errors++; $display("FAIL no_resume got busy/plot=%b state=%0d expected 00 state=%0d", {clear_busy, vga_plot}, dbg_state, IDLE);
        end
    endtask

    // Reference model: each cycle a requester is a candidate if its req is up
    // and it is not in its grant cycle; with two candidates the one served
    // less recently wins. The winner's pixel reaches the adapter if on screen.
    task automatic test_random();
        logic       ep, eo, eplot, eoob;
        logic [7:0] evx;
        logic [6:0] evy;
        logic [2:0] evc;
        logic       obs_served_last;
        logic       cand_p, cand_o, take_p, take_o;
        logic [7:0] wx;
        logic [6:0] wy;
        logic [2:0] wc;
        bit         p_hold, o_hold;
        reset_dut();
        ep = 0; eo = 0; eplot = 0; eoob = 0;
        evx = '0; evy = '0; evc = '0;
        obs_served_last = 1'b1;
        p_hold = 0; o_hold = 0;
        for (int c = 0; c < 400; c++) begin
            checks++;
            if ({p_gnt, o_gnt, vga_plot, oob} !== {ep, eo, eplot, eoob} ||
                (eplot && {vga_x, vga_y, vga_color} !== {evx, evy, evc})) begin
                errors++;
                $display("FAIL random cycle %0d got p/o/plot/oob=%b px=%0d,%0d,%0d expected %b px=%0d,%0d,%0d",
                         c, {p_gnt, o_gnt, vga_plot, oob}, vga_x, vga_y, vga_color,
                         {ep, eo, eplot, eoob}, evx, evy, evc);
            end
            if (ep) begin
                if ($urandom_range(1) == 1) p_req = 1'b0;
                else p_hold = 1;
            end else if (p_hold) begin
                p_req = 1'b0; p_hold = 0;
            end else if (!p_req && $urandom_range(2) == 0) begin
                p_req = 1'b1;
                p_x = 8'($urandom_range(175));
                p_y = 7'($urandom_range(127));
                p_color = 3'($urandom_range(7));
            end
            if (eo) begin
                if ($urandom_range(1) == 1) o_req = 1'b0;
                else o_hold = 1;
            end else if (o_hold) begin
                o_req = 1'b0; o_hold = 0;
            end else if (!o_req && $urandom_range(2) == 0) begin
                o_req = 1'b1;
                o_x = 8'($urandom_range(175));
                o_y = 7'($urandom_range(127));
                o_color = 3'($urandom_range(7));
            end
            cand_p = p_req && !ep;
            cand_o = o_req && !eo;
            take_p = cand_p && (!cand_o || obs_served_last);
            take_o = cand_o && !take_p;
            ep = take_p; eo = take_o; eplot = 0; eoob = 0;
            if (take_p || take_o) begin
                wx = take_p ? p_x : o_x;
                wy = take_p ? p_y : o_y;
                wc = take_p ? p_color : o_color;
                obs_served_last = take_o;
                if (wx < 8'd160 && wy < 7'd120) begin
                    eplot = 1; evx = wx; evy = wy; evc = wc;
                end else begin
                    eoob = 1;
                end
            end
            @(posedge clk); #1;
        end
        p_req = 1'b0; o_req = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b0;
        clear_req = 1'b0; p_req = 1'b0; o_req = 1'b0;
        p_x = '0; p_y = '0; p_color = '0;
        o_x = '0; o_y = '0; o_color = '0;
        test_reset();
        test_single();
        test_back_to_back();
        test_oob();
        test_clear();
        test_collision_and_reset_mid_sweep();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
